gpr_banked_stage: RTL and testbench
===================================

Name: gpr_banked_stage

Overview:
- Per-thread general-purpose register file for the issue pipeline, replacing the flat multi-ported register array.
- Register storage is split into NUM_BANKS single-read/single-write banks. Operand reads that land in the same bank are serialised by a small FSM.
- Operands are returned through a valid/ready response with a request tag.
- Writeback is never stalled. Writeback-to-read bypass within a read cycle is write-first.

Parameters:
- NUM_WARPS, 4, warps; WIDW = max(1, clog2(NUM_WARPS)).
- NUM_REGS, 32, registers per warp, power of 2; RW = clog2(NUM_REGS).
- NUM_THREADS, 4, lanes per warp.
- DATAW, 32, register width.
- NUM_BANKS, 2, power of 2 in the range 1..NUM_REGS; BANKW = clog2(NUM_BANKS).
- NUM_RPORTS, 3, operands per request: 2 or 3. With 2, req_rs3 is ignored and rsp_rs3_data is 0.
- TAGW, 8, width of the pass-through request tag.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- wb_valid  in  1  writeback valid
- wb_ready  out  1  constant 1
- wb_wid  in  WIDW  writeback warp id
- wb_rd  in  RW  destination register
- wb_tmask  in  NUM_THREADS  per-lane write enable
- wb_data  in  NUM_THREADS*DATAW  lane data, lane i at [i*DATAW +: DATAW]
- req_valid  in  1  operand read request
- req_ready  out  1  request accepted when req_valid & req_ready
- req_wid  in  WIDW  request warp id
- req_rs1, req_rs2, req_rs3  in  RW each  source registers
- req_tag  in  TAGW  opaque tag
- rsp_valid  out  1  operands valid
- rsp_ready  in  1  consumer accepts
- rsp_wid  out  WIDW  warp id of the response
- rsp_tag  out  TAGW  tag of the response
- rsp_rs1_data, rsp_rs2_data, rsp_rs3_data  out  NUM_THREADS*DATAW each  operand data

Behaviour:
- Bank mapping:
  - bank(wid, r) = (r[BANKW-1:0] + wid[BANKW-1:0]) mod NUM_BANKS.
  - row = {wid, r >> BANKW}.
  - With NUM_BANKS = 1 there is a single bank and row = {wid, r}.
- Writes:
  - The bank write happens at the clock edge when wb_valid, wb_rd != 0 and wb_tmask[i] are all set, independently per lane.
  - Writes to r0 are dropped.
  - Writes are never blocked by reads.
- r0 and duplicates:
  - An operand equal to 0 returns 0 for all lanes and consumes no bank read.
  - Identical nonzero operands (for example rs1 == rs2) share one bank read.
- Scheduling:
  - On acceptance, the distinct nonzero operands are grouped by bank.
  - Depth K = max over banks of the operand count in that bank, so 0 ≤ K ≤ NUM_RPORTS.
  - Read cycle j (j = 1..K) reads, in every bank, the j-th operand mapped to it, in rs1, rs2, rs3 order.
- FSM states:
  - IDLE: req_ready = 1.
    - Accept with K ≤ 1: the acceptance cycle is the only read cycle; go to RSP.
    - Accept with K > 1: go to READ.
  - READ: req_ready = 0. Issues read cycles 2..K, one per clock; after the last one, go to RSP.
  - RSP: rsp_valid = 1.
    - rsp_ready = 1: req_ready = 1, and a new request can be accepted in the same cycle (back-to-back). Go to RSP if that request has K ≤ 1, READ if K > 1, otherwise IDLE.
    - rsp_ready = 0: hold all rsp_* outputs stable.
- Latency: acceptance at cycle T gives rsp_valid at T + max(K, 1).
- Bank reads:
  - Bank reads are synchronous with 1-cycle latency, captured into per-operand holding registers.
  - A lane read of row X in the same cycle as a write to the same bank and row with that lane's tmask set returns wb_data (write-first).
  - A write to an operand after that operand's read cycle does not change the captured value; the snapshot holds until rsp is accepted.
- Reset:
  - State goes to IDLE; rsp_valid = 0, req_ready = 1.
  - rsp_wid, rsp_tag and rsp data registers reset to 0.
  - An in-flight request is dropped.
  - Bank contents are not cleared.
  - A write presented in the reset cycle is ignored.

Decomposition:
- Shared package gpr_pkg holds:
  - the width constants WIDW, RW, BANKW and the row-address width;
  - a bank-index function;
  - a row-index function;
  - the FSM state enum.
- Sub-module gpr_bank_ram: one instance per bank.
  - 1 write port with per-lane enable, 1 synchronous read port, write-first bypass.
  - Depth NUM_WARPS*NUM_REGS/NUM_BANKS, width NUM_THREADS*DATAW.
  - No r0 handling inside the sub-module.

Test Plan:
- Defaults, wid = 0: write r2 = 0x11, r3 = 0x22 on all lanes, then request rs1 = 2, rs2 = 3 -> operands are in banks 0 and 1, K = 1; rsp_valid at T+1 with 0x11 / 0x22.
- Request wid = 0, rs1 = 2, rs2 = 4, rs3 = 6 (all bank 0) -> K = 3; req_ready low for 2 cycles; rsp_valid at T+3 with the correct values; rsp_tag echoed.
- Request rs1 = 0, rs2 = 0, rs3 = 5 -> K = 1; rs1 and rs2 data are 0. A write to r0 with 0xFFFF followed by a read of r0 -> 0.
- Write r7 = 0xAA with tmask = 0b0101 in the same cycle as a read of r7 (old 0x55) -> lanes 0 and 2 return 0xAA, lanes 1 and 3 return 0x55.
- Hold rsp_ready = 0 for 4 cycles while writing to the captured register -> outputs stay stable at the snapshot values; on release, the next request is accepted the same cycle.
- Assert reset during READ of a K = 3 request -> next cycle rsp_valid = 0, req_ready = 1; a subsequent read returns the pre-reset register values.

Source files
------------

// File: rtl/gpr_pkg.sv
// gpr_pkg: shared widths, bank/row mapping helpers and FSM states for the banked GPR stage
package gpr_pkg;
  localparam int DEF_WARPS = 4;
  localparam int DEF_REGS = 32;
  localparam int DEF_BANKS = 2;
  function automatic int log2c(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
  localparam int WIDW = log2c(DEF_WARPS);
  localparam int RW = $clog2(DEF_REGS);
  localparam int BANKW = $clog2(DEF_BANKS);
  localparam int ROWW = WIDW + RW - BANKW;
  function automatic int bank_idx(input int wid, input int r, input int banks);
    return (wid + r) % banks;
  endfunction
  function automatic int row_idx(input int wid, input int r, input int regs, input int banks);
    return (wid * regs + r) / banks;
  endfunction
  typedef enum logic [1:0] {S_IDLE, S_READ, S_RSP} state_t;
endpackage

// File: rtl/gpr_bank_ram.sv
// gpr_bank_ram: one register bank with per-lane write enables and a write-first synchronous read
module gpr_bank_ram #(
  parameter int DEPTH = 64,
  parameter int AW = 6,
  parameter int NUM_THREADS = 4,
  parameter int DATAW = 32
) (
  input  logic                         clk,
  input  logic [NUM_THREADS-1:0]       we,
  input  logic [AW-1:0]                waddr,
  input  logic [NUM_THREADS*DATAW-1:0] wdata,
  input  logic                         re,
  input  logic [AW-1:0]                raddr,
  output logic [NUM_THREADS*DATAW-1:0] rdata
);
  logic [NUM_THREADS*DATAW-1:0] mem [DEPTH];
  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_THREADS; i++) begin
      if (we[i]) mem[waddr][i*DATAW +: DATAW] <= wdata[i*DATAW +: DATAW];
      if (re) rdata[i*DATAW +: DATAW] <= (we[i] && waddr == raddr) ? wdata[i*DATAW +: DATAW] : mem[raddr][i*DATAW +: DATAW];
    end
  end
endmodule

// File: rtl/gpr_banked_stage.sv
// gpr_banked_stage: banked per-warp register file that serialises same-bank operand reads
module gpr_banked_stage import gpr_pkg::*; #(
  parameter int NUM_WARPS = 4,
  parameter int NUM_REGS = 32,
  parameter int NUM_THREADS = 4,
  parameter int DATAW = 32,
  parameter int NUM_BANKS = 2,
  parameter int NUM_RPORTS = 3,
  parameter int TAGW = 8,
  localparam int WIW = log2c(NUM_WARPS),
  localparam int RGW = $clog2(NUM_REGS),
  localparam int BKW = $clog2(NUM_BANKS),
  localparam int BIW = (BKW > 0) ? BKW : 1,
  localparam int AW = WIW + RGW - BKW,
  localparam int DW = NUM_THREADS * DATAW
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   wb_valid,
  output logic                   wb_ready,
  input  logic [WIW-1:0]         wb_wid,
  input  logic [RGW-1:0]         wb_rd,
  input  logic [NUM_THREADS-1:0] wb_tmask,
  input  logic [DW-1:0]          wb_data,
  input  logic                   req_valid,
  output logic                   req_ready,
  input  logic [WIW-1:0]         req_wid,
  input  logic [RGW-1:0]         req_rs1,
  input  logic [RGW-1:0]         req_rs2,
  input  logic [RGW-1:0]         req_rs3,
  input  logic [TAGW-1:0]        req_tag,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic [WIW-1:0]         rsp_wid,
  output logic [TAGW-1:0]        rsp_tag,
  output logic [DW-1:0]          rsp_rs1_data,
  output logic [DW-1:0]          rsp_rs2_data,
  output logic [DW-1:0]          rsp_rs3_data
);
  state_t state, state_n;
  logic accept, dup1;
  logic [RGW-1:0] rs [3];
  logic [2:0] n_act, c_act, rz;
  logic [BIW-1:0] n_bank [3], rbank [3], c_bank [3], wb_bank;
  logic [AW-1:0] n_row [3], rrow [3], c_row [3], wb_row;
  logic [1:0] n_slot [3], rslot [3], c_slot [3];
  logic [1:0] k_new, kreg, cnt, c_s;
  logic [DW-1:0] hold [3], rsp_d [3];
  logic [DW-1:0] rdata [NUM_BANKS];
  logic [NUM_BANKS-1:0] re;
  logic [AW-1:0] raddr [NUM_BANKS];
  assign rs[0] = req_rs1;
  assign rs[1] = req_rs2;
  assign rs[2] = req_rs3;
  always_comb begin
    for (int n = 0; n < 3; n++) begin
      n_act[n] = (rs[n] != '0) && (n < NUM_RPORTS);
      n_bank[n] = BIW'(bank_idx(int'(req_wid), int'(rs[n]), NUM_BANKS));
      n_row[n] = AW'(row_idx(int'(req_wid), int'(rs[n]), NUM_REGS, NUM_BANKS));
    end
  end
  // duplicates inherit the slot of the operand they alias and add no bank pressure
  assign dup1 = n_act[0] && n_act[1] && rs[1] == rs[0];
  always_comb begin
    n_slot[0] = 2'd0;
    n_slot[1] = dup1 ? 2'd0 : {1'b0, n_act[0] && n_bank[0] == n_bank[1]};
    n_slot[2] = (n_act[0] && rs[2] == rs[0]) ? 2'd0 :
                (n_act[1] && rs[2] == rs[1]) ? n_slot[1] :
                {1'b0, n_act[0] && n_bank[0] == n_bank[2]} + {1'b0, n_act[1] && !dup1 && n_bank[1] == n_bank[2]};
    k_new = {1'b0, n_act[0]};
    for (int n = 1; n < 3; n++) if (n_act[n] && n_slot[n] + 2'd1 > k_new) k_new = n_slot[n] + 2'd1;
  end
  assign wb_ready = 1'b1;
  assign rsp_valid = state == S_RSP;
  assign req_ready = state == S_IDLE || (state == S_RSP && rsp_ready);
  assign accept = req_valid && req_ready;
  always_comb begin
    state_n = state;
    if (accept) state_n = (k_new > 2'd1) ? S_READ : S_RSP;
    else if (state == S_READ && cnt == kreg - 2'd1) state_n = S_RSP;
    else if (state == S_RSP && rsp_ready) state_n = S_IDLE;
  end
  assign c_s = accept ? 2'd0 : cnt;
  always_comb begin
    for (int n = 0; n < 3; n++) begin
      c_act[n] = accept ? n_act[n] : !rz[n];
      c_bank[n] = accept ? n_bank[n] : rbank[n];
      c_row[n] = accept ? n_row[n] : rrow[n];
      c_slot[n] = accept ? n_slot[n] : rslot[n];
    end
    for (int b = 0; b < NUM_BANKS; b++) begin
      re[b] = 1'b0;
      raddr[b] = '0;
      for (int n = 0; n < 3; n++)
        if ((accept || state == S_READ) && c_act[n] && c_bank[n] == BIW'(b) && c_slot[n] == c_s) begin
          re[b] = 1'b1;
          raddr[b] = c_row[n];
        end
    end
  end
  assign wb_bank = BIW'(bank_idx(int'(wb_wid), int'(wb_rd), NUM_BANKS));
  assign wb_row = AW'(row_idx(int'(wb_wid), int'(wb_rd), NUM_REGS, NUM_BANKS));
  for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
    gpr_bank_ram #(.DEPTH(NUM_WARPS * NUM_REGS / NUM_BANKS), .AW(AW), .NUM_THREADS(NUM_THREADS), .DATAW(DATAW)) u_ram (
      .clk(clk),
      .we((wb_valid && !reset && wb_rd != '0 && wb_bank == BIW'(b)) ? wb_tmask : '0),
      .waddr(wb_row),
      .wdata(wb_data),
      .re(re[b]),
      .raddr(raddr[b]),
      .rdata(rdata[b])
    );
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_IDLE;
      rz <= '1;
      kreg <= '0;
      cnt <= '0;
      rsp_wid <= '0;
      rsp_tag <= '0;
      for (int n = 0; n < 3; n++) begin
        hold[n] <= '0;
        rbank[n] <= '0;
        rrow[n] <= '0;
        rslot[n] <= '0;
      end
    end else begin
      state <= state_n;
      // each read cycle also banks the operands fetched in the previous one
      if (state == S_READ) begin
        cnt <= cnt + 2'd1;
        for (int n = 0; n < 3; n++) if (rslot[n] == cnt - 2'd1) hold[n] <= rdata[rbank[n]];
      end
      if (accept) begin
        cnt <= 2'd1;
        kreg <= k_new;
        rz <= ~n_act;
        rsp_wid <= req_wid;
        rsp_tag <= req_tag;
        for (int n = 0; n < 3; n++) begin
          rbank[n] <= n_bank[n];
          rrow[n] <= n_row[n];
          rslot[n] <= n_slot[n];
        end
      end
    end
  end
  // last-slot operands are still sitting in their bank's read register
  always_comb for (int n = 0; n < 3; n++) rsp_d[n] = rz[n] ? '0 : (rslot[n] == kreg - 2'd1) ? rdata[rbank[n]] : hold[n];
  assign rsp_rs1_data = rsp_d[0];
  assign rsp_rs2_data = rsp_d[1];
  assign rsp_rs3_data = rsp_d[2];
endmodule

// File: tb/tb_gpr_banked_stage.sv
// tb_gpr_banked_stage: directed checks of banking, conflicts, bypass, stall and reset
module tb_gpr_banked_stage;
  import gpr_pkg::*;
  localparam int DW = 128;
  logic clk = 0, reset = 1;
  logic wb_valid = 0, wb_ready;
  logic [WIDW-1:0] wb_wid = '0;
  logic [RW-1:0] wb_rd = '0;
  logic [3:0] wb_tmask = '0;
  logic [DW-1:0] wb_data = '0;
  logic req_valid = 0, req_ready;
  logic [WIDW-1:0] req_wid = '0;
  logic [RW-1:0] req_rs1 = '0, req_rs2 = '0, req_rs3 = '0;
  logic [7:0] req_tag = '0;
  logic rsp_valid, rsp_ready = 1;
  logic [WIDW-1:0] rsp_wid;
  logic [7:0] rsp_tag;
  logic [DW-1:0] rsp_rs1_data, rsp_rs2_data, rsp_rs3_data;
  int errors = 0, checks = 0;
  gpr_banked_stage dut (
    .clk(clk), .reset(reset),
    .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_wid(wb_wid), .wb_rd(wb_rd), .wb_tmask(wb_tmask), .wb_data(wb_data),
    .req_valid(req_valid), .req_ready(req_ready), .req_wid(req_wid),
    .req_rs1(req_rs1), .req_rs2(req_rs2), .req_rs3(req_rs3), .req_tag(req_tag),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_wid(rsp_wid), .rsp_tag(rsp_tag),
    .rsp_rs1_data(rsp_rs1_data), .rsp_rs2_data(rsp_rs2_data), .rsp_rs3_data(rsp_rs3_data)
  );
  always #5 clk = ~clk;
  function automatic logic [DW-1:0] rep(input logic [31:0] v);
    return {4{v}};
  endfunction
  task automatic wr(input logic [WIDW-1:0] w, input logic [RW-1:0] rd, input logic [3:0] m, input logic [31:0] v);
    wb_valid = 1; wb_wid = w; wb_rd = rd; wb_tmask = m; wb_data = rep(v);
    @(negedge clk);
    wb_valid = 0;
  endtask
  task automatic rq(input logic [WIDW-1:0] w, input logic [RW-1:0] a, input logic [RW-1:0] b, input logic [RW-1:0] c, input logic [7:0] t);
    req_valid = 1; req_wid = w; req_rs1 = a; req_rs2 = b; req_rs3 = c; req_tag = t;
    @(negedge clk);
    req_valid = 0;
  endtask
  task automatic test_reset;
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL rst_valid got=%0b exp=0", rsp_valid); end
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL rst_ready got=%0b exp=1", req_ready); end
    checks++; if (wb_ready !== 1'b1) begin errors++; $display("FAIL wb_ready got=%0b exp=1", wb_ready); end
    checks++; if (rsp_tag !== 8'h00) begin errors++; $display("FAIL rst_tag got=%h exp=00", rsp_tag); end
    checks++; if (rsp_rs1_data !== '0) begin errors++; $display("FAIL rst_data got=%h exp=0", rsp_rs1_data); end
  endtask
  task automatic test_two_banks;
    wr(0, 2, 4'hF, 32'h11);
    wr(0, 3, 4'hF, 32'h22);
    rq(0, 2, 3, 0, 8'h5A);
    checks++; if (rsp_valid !== 1'b1) begin errors++; $display("FAIL k1_valid got=%0b exp=1", rsp_valid); end
    checks++; if (rsp_rs1_data !== rep(32'h11)) begin errors++; $display("FAIL k1_rs1 got=%h exp=%h", rsp_rs1_data, rep(32'h11)); end
    checks++; if (rsp_rs2_data !== rep(32'h22)) begin errors++; $display("FAIL k1_rs2 got=%h exp=%h", rsp_rs2_data, rep(32'h22)); end
    checks++; if (rsp_rs3_data !== '0) begin errors++; $display("FAIL k1_rs3 got=%h exp=0", rsp_rs3_data); end
    checks++; if (rsp_tag !== 8'h5A) begin errors++; $display("FAIL k1_tag got=%h exp=5a", rsp_tag); end
    @(negedge clk);
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL k1_done got=%0b exp=0", rsp_valid); end
  endtask
  task automatic test_conflict;
    wr(0, 4, 4'hF, 32'h44);
    wr(0, 6, 4'hF, 32'h66);
    rq(0, 2, 4, 6, 8'hC3);
    checks++; if ({req_ready, rsp_valid} !== 2'b00) begin errors++; $display("FAIL k3_c1 got=%b exp=00", {req_ready, rsp_valid}); end
    @(negedge clk);
    checks++; if ({req_ready, rsp_valid} !== 2'b00) begin errors++; $display("FAIL k3_c2 got=%b exp=00", {req_ready, rsp_valid}); end
    @(negedge clk);
    checks++; if (rsp_valid !== 1'b1) begin errors++; $display("FAIL k3_valid got=%0b exp=1", rsp_valid); end
    checks++; if (rsp_rs1_data !== rep(32'h11)) begin errors++; $display("FAIL k3_rs1 got=%h exp=%h", rsp_rs1_data, rep(32'h11)); end
    checks++; if (rsp_rs2_data !== rep(32'h44)) begin errors++; $display("FAIL k3_rs2 got=%h exp=%h", rsp_rs2_data, rep(32'h44)); end
    checks++; if (rsp_rs3_data !== rep(32'h66)) begin errors++; $display("FAIL k3_rs3 got=%h exp=%h", rsp_rs3_data, rep(32'h66)); end
    checks++; if (rsp_tag !== 8'hC3) begin errors++; $display("FAIL k3_tag got=%h exp=c3", rsp_tag); end
    @(negedge clk);
  endtask
  task automatic test_zero_dup;
    wr(0, 5, 4'hF, 32'h55);
    rq(0, 0, 0, 5, 8'h01);
    checks++; if (rsp_valid !== 1'b1) begin errors++; $display("FAIL r0_valid got=%0b exp=1", rsp_valid); end
    checks++; if ({rsp_rs1_data, rsp_rs2_data} !== '0) begin errors++; $display("FAIL r0_zero got=%h exp=0", {rsp_rs1_data, rsp_rs2_data}); end
    checks++; if (rsp_rs3_data !== rep(32'h55)) begin errors++; $display("FAIL r0_rs3 got=%h exp=%h", rsp_rs3_data, rep(32'h55)); end
    @(negedge clk);
    wr(0, 0, 4'hF, 32'hFFFF);
    rq(0, 0, 2, 2, 8'h02);
    checks++; if (rsp_rs1_data !== '0) begin errors++; $display("FAIL r0_write got=%h exp=0", rsp_rs1_data); end
    checks++; if ({rsp_rs2_data, rsp_rs3_data} !== {rep(32'h11), rep(32'h11)}) begin errors++; $display("FAIL dup got=%h exp=%h", {rsp_rs2_data, rsp_rs3_data}, {rep(32'h11), rep(32'h11)}); end
    @(negedge clk);
    rq(0, 0, 0, 0, 8'h04);
    checks++; if ({rsp_valid, rsp_tag} !== {1'b1, 8'h04}) begin errors++; $display("FAIL k0 got=%h exp=104", {rsp_valid, rsp_tag}); end
    @(negedge clk);
    wr(1, 3, 4'hF, 32'h33);
    wr(1, 2, 4'hF, 32'h12);
    rq(1, 3, 2, 0, 8'h03);
    checks++; if (rsp_wid !== 2'd1) begin errors++; $display("FAIL w1_wid got=%0d exp=1", rsp_wid); end
    checks++; if ({rsp_rs1_data, rsp_rs2_data} !== {rep(32'h33), rep(32'h12)}) begin errors++; $display("FAIL w1_data got=%h exp=%h", {rsp_rs1_data, rsp_rs2_data}, {rep(32'h33), rep(32'h12)}); end
    @(negedge clk);
  endtask
  task automatic test_bypass;
    wr(0, 7, 4'hF, 32'h55);
    wb_valid = 1; wb_wid = 0; wb_rd = 7; wb_tmask = 4'b0101; wb_data = rep(32'hAA);
    rq(0, 7, 0, 0, 8'h05);
    wb_valid = 0;
    checks++; if (rsp_rs1_data !== {32'h55, 32'hAA, 32'h55, 32'hAA}) begin errors++; $display("FAIL bypass got=%h exp=%h", rsp_rs1_data, {32'h55, 32'hAA, 32'h55, 32'hAA}); end
    @(negedge clk);
    rq(0, 7, 0, 0, 8'h06);
    checks++; if (rsp_rs1_data !== {32'h55, 32'hAA, 32'h55, 32'hAA}) begin errors++; $display("FAIL bypass_after got=%h exp=%h", rsp_rs1_data, {32'h55, 32'hAA, 32'h55, 32'hAA}); end
    @(negedge clk);
  endtask
  task automatic test_back_to_back;
    rsp_ready = 0;
    rq(0, 4, 5, 0, 8'h77);
    req_valid = 1; req_rs1 = 4; req_rs2 = 0; req_rs3 = 0; req_tag = 8'h78;
    for (int i = 0; i < 4; i++) begin
      checks++; if ({rsp_valid, req_ready, rsp_tag} !== {2'b10, 8'h77}) begin errors++; $display("FAIL stall_ctl%0d got=%h exp=277", i, {rsp_valid, req_ready, rsp_tag}); end
      checks++; if ({rsp_rs1_data, rsp_rs2_data} !== {rep(32'h44), rep(32'h55)}) begin errors++; $display("FAIL stall_data%0d got=%h exp=%h", i, {rsp_rs1_data, rsp_rs2_data}, {rep(32'h44), rep(32'h55)}); end
      wb_valid = 1; wb_wid = 0; wb_rd = 4; wb_tmask = 4'hF; wb_data = rep(32'h99);
      @(negedge clk);
    end
    wb_valid = 0;
    checks++; if (rsp_rs1_data !== rep(32'h44)) begin errors++; $display("FAIL stall_snap got=%h exp=%h", rsp_rs1_data, rep(32'h44)); end
    rsp_ready = 1;
    #1;
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL release_ready got=%0b exp=1", req_ready); end
    @(negedge clk);
    req_valid = 0;
    checks++; if ({rsp_valid, rsp_tag} !== {1'b1, 8'h78}) begin errors++; $display("FAIL b2b_tag got=%h exp=178", {rsp_valid, rsp_tag}); end
    checks++; if (rsp_rs1_data !== rep(32'h99)) begin errors++; $display("FAIL b2b_data got=%h exp=%h", rsp_rs1_data, rep(32'h99)); end
    @(negedge clk);
  endtask
  task automatic test_reset_mid;
    rq(0, 2, 4, 6, 8'hE1);
    reset = 1;
    wb_valid = 1; wb_wid = 0; wb_rd = 2; wb_tmask = 4'hF; wb_data = rep(32'hDEAD);
    @(negedge clk);
    reset = 0; wb_valid = 0;
    checks++; if ({rsp_valid, req_ready} !== 2'b01) begin errors++; $display("FAIL mid_rst got=%b exp=01", {rsp_valid, req_ready}); end
    checks++; if ({rsp_tag, rsp_rs1_data} !== '0) begin errors++; $display("FAIL mid_rst_regs got=%h exp=0", {rsp_tag, rsp_rs1_data}); end
    rq(0, 2, 4, 6, 8'hE2);
    @(negedge clk);
    @(negedge clk);
    checks++; if ({rsp_valid, rsp_tag} !== {1'b1, 8'hE2}) begin errors++; $display("FAIL post_rst_tag got=%h exp=1e2", {rsp_valid, rsp_tag}); end
    checks++; if ({rsp_rs1_data, rsp_rs2_data, rsp_rs3_data} !== {rep(32'h11), rep(32'h99), rep(32'h66)}) begin errors++; $display("FAIL post_rst_data got=%h exp=%h", {rsp_rs1_data, rsp_rs2_data, rsp_rs3_data}, {rep(32'h11), rep(32'h99), rep(32'h66)}); end
    @(negedge clk);
  endtask
  initial begin
    repeat (3) @(negedge clk);
    reset = 0;
    test_reset;
    test_two_banks;
    test_conflict;
    test_zero_dup;
    test_bypass;
    test_back_to_back;
    test_reset_mid;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
